// File: rtl/regfile_wb_if.sv
// Decode/write-back side bus of the register file: WB commit, two read ports, issue scoreboard.
// The master modport is the pipeline (decode + WB stage); the slave modport is the register file.
interface regfile_wb_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned WB_DATA_BUS = 5 + 1 + XLEN
);
    logic [WB_DATA_BUS-1:0] wb_data_bus_in;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic                   issue_valid;
    logic [4:0]             issue_rd;
    logic                   issue_rd_wen;
    logic                   issue_ready;

    modport master (
        output wb_data_bus_in, rs1_addr, rs2_addr, issue_valid, issue_rd, issue_rd_wen,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready
    );

    modport slave (
        input  wb_data_bus_in, rs1_addr, rs2_addr, issue_valid, issue_rd, issue_rd_wen,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready
    );
endinterface

// File: rtl/regfile_wb.sv
// Integer register file x0..x31 with write-first bypass and a per-register pending-write
// scoreboard; decode stalls on busy operands and on a saturated destination counter.
module regfile_wb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned WB_DATA_BUS = 5 + 1 + XLEN,
    parameter int unsigned PEND_W      = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_wb_if.slave  bus
);
    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [32];
    logic [XLEN-1:0]   regs_d [32];
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];

    logic [4:0]      wb_rd;
    logic            wb_wen;
    logic [XLEN-1:0] wb_data;
    logic            wb_hit;

    assign wb_rd   = bus.wb_data_bus_in[WB_DATA_BUS-1 -: 5];
    assign wb_wen  = bus.wb_data_bus_in[XLEN];
    assign wb_data = bus.wb_data_bus_in[XLEN-1:0];
    assign wb_hit  = wb_wen && (wb_rd != 5'd0);

    logic rs1_byp, rs2_byp;
    logic issue_dec;
    logic issue_inc;

    always_comb begin
        rs1_byp = wb_hit && (wb_rd == bus.rs1_addr);
        rs2_byp = wb_hit && (wb_rd == bus.rs2_addr);

        bus.rs1_data = (bus.rs1_addr == 5'd0) ? '0 : (rs1_byp ? wb_data : regs_q[bus.rs1_addr]);
        bus.rs2_data = (bus.rs2_addr == 5'd0) ? '0 : (rs2_byp ? wb_data : regs_q[bus.rs2_addr]);

        // The final outstanding write retiring now is already visible via the bypass.
        bus.rs1_busy = (pend_q[bus.rs1_addr] != '0) &&
                       !(rs1_byp && (pend_q[bus.rs1_addr] == PendOne));
        bus.rs2_busy = (pend_q[bus.rs2_addr] != '0) &&
                       !(rs2_byp && (pend_q[bus.rs2_addr] == PendOne));

        issue_dec = wb_hit && (wb_rd == bus.issue_rd) && (pend_q[bus.issue_rd] != '0);
        bus.issue_ready = !(bus.issue_valid && bus.issue_rd_wen && (bus.issue_rd != 5'd0) &&
                            (pend_q[bus.issue_rd] == PendMax) && !issue_dec);
        issue_inc = bus.issue_valid && bus.issue_rd_wen && bus.issue_ready &&
                    (bus.issue_rd != 5'd0);
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wb_hit) begin
            regs_d[wb_rd] = wb_data;
        end
        for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = issue_inc && (bus.issue_rd == 5'(r));
            dec = wb_hit && (wb_rd == 5'(r)) && (pend_q[r] != '0);
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PendOne;
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - PendOne;
            end
        end
        pend_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, bypass, x0 handling, busy tracking, saturation, reset
// in flight.
module tb_regfile_wb;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_wb_if #(.XLEN(32)) bus ();

    regfile_wb #(.XLEN(32), .WB_DATA_BUS(38), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic wen, input logic [31:0] data);
        bus.wb_data_bus_in = {rd, wen, data};
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic wen);
        bus.issue_valid  = v;
        bus.issue_rd     = rd;
        bus.issue_rd_wen = wen;
    endtask

    initial begin
        rst = 1'b1;
        set_wb(5'd0, 1'b0, 32'h0);
        set_issue(1'b0, 5'd0, 1'b0);
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state across all addresses
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(31 - a);
            #1;
            chk("rst_rs1_data", bus.rs1_data, 32'h0);
            chk("rst_rs2_data", bus.rs2_data, 32'h0);
            chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'h0);
            chk("rst_rs2_busy", 32'(bus.rs2_busy), 32'h0);
        end
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'h1);

        // Write x5 with same-cycle bypass, then from the array
        set_wb(5'd5, 1'b1, 32'hDEADBEEF);
        bus.rs1_addr = 5'd5;
        #1;
        chk("x5_bypass", bus.rs1_data, 32'hDEADBEEF);
        step();
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        chk("x5_stored", bus.rs1_data, 32'hDEADBEEF);

        // Writes and issues to x0 are dropped
        set_wb(5'd0, 1'b1, 32'h1234);
        set_issue(1'b1, 5'd0, 1'b1);
        bus.rs1_addr = 5'd0;
        #1;
        chk("x0_bypass", bus.rs1_data, 32'h0);
        chk("x0_busy_now", 32'(bus.rs1_busy), 32'h0);
        step();
        set_wb(5'd0, 1'b0, 32'h0);
        set_issue(1'b0, 5'd0, 1'b0);
        #1;
        chk("x0_stored", bus.rs1_data, 32'h0);
        chk("x0_busy_after", 32'(bus.rs1_busy), 32'h0);

        // Two issues to x7, then two write-backs
        set_issue(1'b1, 5'd7, 1'b1);
        bus.rs2_addr = 5'd7;
        #1;
        chk("x7_ready_1", 32'(bus.issue_ready), 32'h1);
        step();
        chk("x7_busy_1", 32'(bus.rs2_busy), 32'h1);
        step();
        set_issue(1'b0, 5'd0, 1'b0);
        #1;
        chk("x7_busy_2", 32'(bus.rs2_busy), 32'h1);
        set_wb(5'd7, 1'b1, 32'h1111);
        #1;
        chk("x7_wb1_busy", 32'(bus.rs2_busy), 32'h1);
        chk("x7_wb1_data", bus.rs2_data, 32'h1111);
        step();
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        chk("x7_between_busy", 32'(bus.rs2_busy), 32'h1);
        set_wb(5'd7, 1'b1, 32'h2222);
        #1;
        chk("x7_wb2_busy", 32'(bus.rs2_busy), 32'h0);
        chk("x7_wb2_data", bus.rs2_data, 32'h2222);
        step();
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        chk("x7_done_busy", 32'(bus.rs2_busy), 32'h0);
        chk("x7_done_data", bus.rs2_data, 32'h2222);

        // Saturate x9 with three issues
        bus.rs1_addr = 5'd9;
        set_issue(1'b1, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("x9_ready_fill", 32'(bus.issue_ready), 32'h1);
            step();
        end
        chk("x9_ready_full", 32'(bus.issue_ready), 32'h0);
        chk("x9_busy_full", 32'(bus.rs1_busy), 32'h1);
        step();
        chk("x9_ready_held", 32'(bus.issue_ready), 32'h0);
        // Fourth issue alongside a write-back is accepted; count stays at three
        set_wb(5'd9, 1'b1, 32'h99);
        #1;
        chk("x9_ready_with_wb", 32'(bus.issue_ready), 32'h1);
        step();
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        chk("x9_ready_still_full", 32'(bus.issue_ready), 32'h0);
        set_issue(1'b0, 5'd0, 1'b0);
        // Drain the three outstanding writes
        for (int i = 0; i < 3; i++) begin
            set_wb(5'd9, 1'b1, 32'(32'hA0 + i));
            #1;
            chk("x9_drain_busy", 32'(bus.rs1_busy), (i == 2) ? 32'h0 : 32'h1);
            chk("x9_drain_data", bus.rs1_data, 32'(32'hA0 + i));
            step();
        end
        set_wb(5'd0, 1'b0, 32'h0);
        #1;
        chk("x9_drained_busy", 32'(bus.rs1_busy), 32'h0);
        chk("x9_drained_data", bus.rs1_data, 32'hA2);

        // Reset in flight overrides write-back and issue
        set_issue(1'b1, 5'd3, 1'b1);
        step();
        set_issue(1'b1, 5'd4, 1'b1);
        set_wb(5'd3, 1'b1, 32'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_issue(1'b0, 5'd0, 1'b0);
        set_wb(5'd0, 1'b0, 32'h0);
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd4;
        #1;
        chk("rst3_data", bus.rs1_data, 32'h0);
        chk("rst3_busy", 32'(bus.rs1_busy), 32'h0);
        chk("rst4_busy", 32'(bus.rs2_busy), 32'h0);
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd9;
        #1;
        chk("rst5_data", bus.rs1_data, 32'h0);
        chk("rst9_data", bus.rs2_data, 32'h0);
        step();
        bus.rs1_addr = 5'd3;
        #1;
        chk("rst3_data_later", bus.rs1_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
